// File: rtl/mpsoc_boot_pkg.sv
// mpsoc_boot_pkg
// Shared definitions for the MPSoC boot sequencer:
//   - boot_state_e : 2-bit FSM encoding (HOLD=0, RELEASE=1, WAIT_EN=2, RUN=3)
//   - *_DEF        : default tile count, reset hold, release stagger, counter width
package mpsoc_boot_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,  // all tiles in reset, counting the hold interval
    RELEASE = 2'd1,  // releasing tiles one by one, STAGGER cycles apart
    WAIT_EN = 2'd2,  // all tiles out of reset, CPUs gated off
    RUN     = 2'd3   // CPUs enabled
  } boot_state_e;

  localparam int TILE_NUM_DEF = 4;
  localparam int RST_HOLD_DEF = 20;
  localparam int STAGGER_DEF  = 4;
  localparam int CNT_W_DEF    = 8;

endpackage

// File: rtl/mpsoc_boot_sequencer_boot_cnt.sv
// boot_cnt
// CNT_W-bit up-counter shared by the HOLD and RELEASE intervals.
// Ports:
//   clk   in  clock
//   clr   in  synchronous clear (takes priority over en)
//   en    in  count enable
//   term  in  terminal value to compare against
//   hit   out counter currently equals term
module boot_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             hit
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr)     cnt <= '0;
    else if (en) cnt <= cnt + CNT_W'(1);
  end

  assign hit = (cnt == term);

endmodule

// File: rtl/mpsoc_boot_sequencer.sv
// mpsoc_boot_sequencer
// Turns the raw system reset and processor-enable pins into staggered per-tile
// reset releases and a gated per-tile CPU enable.
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-high system reset
//   processors_en  in   level request to run the CPUs
//   tile_reset     out  [TILE_NUM] per-tile reset, active-high
//   cpu_en         out  [TILE_NUM] per-tile CPU enable
//   boot_done      out  all tile resets released
//   busy           out  sequencing in progress (HOLD or RELEASE)
module mpsoc_boot_sequencer
  import mpsoc_boot_pkg::*;
#(
  parameter int TILE_NUM = TILE_NUM_DEF,
  parameter int RST_HOLD = RST_HOLD_DEF,
  parameter int STAGGER  = STAGGER_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                processors_en,
  output logic [TILE_NUM-1:0] tile_reset,
  output logic [TILE_NUM-1:0] cpu_en,
  output logic                boot_done,
  output logic                busy
);

  localparam int IDX_W = $clog2(TILE_NUM) + 1;

  // HOLD starts from a counter cleared at the reset edge, so matching at
  // RST_HOLD lands the release exactly RST_HOLD edges after E0. RELEASE is
  // entered with the counter already cleared on the release edge, so the
  // match is one lower to keep the spacing at STAGGER edges.
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(RST_HOLD);
  localparam logic [CNT_W-1:0] REL_TERM  = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TILE_NUM - 1);

  boot_state_e      state;
  logic [IDX_W-1:0] idx;
  logic             sequencing;
  logic             hit;
  logic [CNT_W-1:0] term;

  assign sequencing = (state == HOLD) || (state == RELEASE);
  assign term       = (state == HOLD) ? HOLD_TERM : REL_TERM;

  boot_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .clr  (reset || (sequencing && hit)),
    .en   (sequencing),
    .term (term),
    .hit  (hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HOLD;
      idx        <= '0;
      tile_reset <= '1;
      cpu_en     <= '0;
      boot_done  <= 1'b0;
      busy       <= 1'b1;
    end else begin
      case (state)
        HOLD: begin
          if (hit) begin
            tile_reset[0] <= 1'b0;
            if (TILE_NUM == 1) begin
              state     <= WAIT_EN;
              boot_done <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state <= RELEASE;
              idx   <= IDX_W'(1);
            end
          end
        end
        RELEASE: begin
          if (hit) begin
            for (int i = 0; i < TILE_NUM; i++)
              if (idx == IDX_W'(i)) tile_reset[i] <= 1'b0;
            idx <= idx + IDX_W'(1);
            if (idx == LAST_IDX) begin
              state     <= WAIT_EN;
              boot_done <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        WAIT_EN: begin
          if (processors_en) begin
            cpu_en <= '1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (!processors_en) begin
            cpu_en <= '0;
            state  <= WAIT_EN;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_mpsoc_boot_sequencer.sv
// Scoreboard bench: the driver pushes hand-computed expected outputs tagged
// with the edge number they must appear after; the monitor samples 2 time
// units after each rising edge and retires every entry due at that edge.
// d0: defaults, d1: RST_HOLD=1/STAGGER=1, d2: TILE_NUM=1/RST_HOLD=5.
module tb_mpsoc_boot_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2, en0, en1, en2;
  logic [3:0] tr0, ce0, tr1, ce1;
  logic       tr2, ce2;
  logic       bd0, bz0, bd1, bz1, bd2, bz2;

  mpsoc_boot_sequencer #(.TILE_NUM(4), .RST_HOLD(20), .STAGGER(4), .CNT_W(8)) d0 (
    .clk(clk), .reset(rst0), .processors_en(en0),
    .tile_reset(tr0), .cpu_en(ce0), .boot_done(bd0), .busy(bz0));

  mpsoc_boot_sequencer #(.TILE_NUM(4), .RST_HOLD(1), .STAGGER(1), .CNT_W(8)) d1 (
    .clk(clk), .reset(rst1), .processors_en(en1),
    .tile_reset(tr1), .cpu_en(ce1), .boot_done(bd1), .busy(bz1));

  mpsoc_boot_sequencer #(.TILE_NUM(1), .RST_HOLD(5), .STAGGER(4), .CNT_W(8)) d2 (
    .clk(clk), .reset(rst2), .processors_en(en2),
    .tile_reset(tr2), .cpu_en(ce2), .boot_done(bd2), .busy(bz2));

  typedef struct {
    int         cyc;
    int         dut;
    logic [3:0] tr;
    logic [3:0] ce;
    logic       bd;
    logic       bz;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input int d, input logic [3:0] tr,
                      input logic [3:0] ce, input logic bd, input logic bz,
                      input string n);
    exp_t e;
    e.cyc = c; e.dut = d; e.tr = tr; e.ce = ce; e.bd = bd; e.bz = bz; e.name = n;
    sb.push_back(e);
  endtask

  task automatic check_one(input exp_t e);
    logic [3:0] a_tr, a_ce;
    logic       a_bd, a_bz;
    case (e.dut)
      0:       begin a_tr = tr0;          a_ce = ce0;          a_bd = bd0; a_bz = bz0; end
      1:       begin a_tr = tr1;          a_ce = ce1;          a_bd = bd1; a_bz = bz1; end
      default: begin a_tr = {3'b000, tr2}; a_ce = {3'b000, ce2}; a_bd = bd2; a_bz = bz2; end
    endcase
    checks++;
    if (e.cyc < cyc) begin
      errors++;
      $display("FAIL %s d%0d: expectation for edge %0d never checked (now %0d)",
               e.name, e.dut, e.cyc, cyc);
    end else if (a_tr !== e.tr || a_ce !== e.ce || a_bd !== e.bd || a_bz !== e.bz) begin
      errors++;
      $display("FAIL %s d%0d edge %0d: got tr=%b ce=%b bd=%b busy=%b, want tr=%b ce=%b bd=%b busy=%b",
               e.name, e.dut, cyc, a_tr, a_ce, a_bd, a_bz, e.tr, e.ce, e.bd, e.bz);
    end
  endtask

  // Monitor
  initial forever begin
    @(posedge clk);
    #2;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        check_one(sb[i]);
        sb.delete(i);
      end
    end
  end

  task automatic wait_edge(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Driver
  initial begin
    int e0, e1;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    en0  = 1'b1; en1  = 1'b1; en2  = 1'b1;

    // ---- default sequence, all three DUTs released together
    wait_edge(10);
    push(11, 0, 4'b1111, 4'b0000, 1'b0, 1'b1, "reset_state");
    push(11, 1, 4'b1111, 4'b0000, 1'b0, 1'b1, "reset_state");
    push(11, 2, 4'b0001, 4'b0000, 1'b0, 1'b1, "reset_state");
    wait_edge(20);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    e0 = cyc + 1;
    push(e0,    0, 4'b1111, 4'b0000, 1'b0, 1'b1, "hold_e0");
    push(e0+19, 0, 4'b1111, 4'b0000, 1'b0, 1'b1, "hold_end");
    push(e0+20, 0, 4'b1110, 4'b0000, 1'b0, 1'b1, "tile0_rel");
    push(e0+23, 0, 4'b1110, 4'b0000, 1'b0, 1'b1, "tile1_pre");
    push(e0+24, 0, 4'b1100, 4'b0000, 1'b0, 1'b1, "tile1_rel");
    push(e0+28, 0, 4'b1000, 4'b0000, 1'b0, 1'b1, "tile2_rel");
    push(e0+31, 0, 4'b1000, 4'b0000, 1'b0, 1'b1, "tile3_pre");
    push(e0+32, 0, 4'b0000, 4'b0000, 1'b1, 1'b0, "boot_done");
    push(e0+33, 0, 4'b0000, 4'b1111, 1'b1, 1'b0, "cpu_en_rise");
    push(e0,    1, 4'b1111, 4'b0000, 1'b0, 1'b1, "s1_e0");
    push(e0+1,  1, 4'b1110, 4'b0000, 1'b0, 1'b1, "s1_t0");
    push(e0+2,  1, 4'b1100, 4'b0000, 1'b0, 1'b1, "s1_t1");
    push(e0+3,  1, 4'b1000, 4'b0000, 1'b0, 1'b1, "s1_t2");
    push(e0+4,  1, 4'b0000, 4'b0000, 1'b1, 1'b0, "s1_t3_done");
    push(e0+5,  1, 4'b0000, 4'b1111, 1'b1, 1'b0, "s1_cpu_en");
    push(e0+4,  2, 4'b0001, 4'b0000, 1'b0, 1'b1, "t1_hold");
    push(e0+5,  2, 4'b0000, 4'b0000, 1'b1, 1'b0, "t1_done");
    push(e0+6,  2, 4'b0000, 4'b0001, 1'b1, 1'b0, "t1_cpu_en");
    wait_edge(e0 + 40);

    // ---- reset from RUN with processors_en dropped; enable held low till E0+50
    rst0 = 1'b1; en0 = 1'b0;
    push(cyc+1, 0, 4'b1111, 4'b0000, 1'b0, 1'b1, "reset_from_run");
    @(negedge clk);
    rst0 = 1'b0;
    e0 = cyc + 1;
    push(e0+32, 0, 4'b0000, 4'b0000, 1'b1, 1'b0, "en_low_done");
    push(e0+50, 0, 4'b0000, 4'b0000, 1'b1, 1'b0, "en_low_e50");
    push(e0+51, 0, 4'b0000, 4'b1111, 1'b1, 1'b0, "en_rise_e51");
    push(e0+60, 0, 4'b0000, 4'b1111, 1'b1, 1'b0, "en_held_e60");
    push(e0+61, 0, 4'b0000, 4'b0000, 1'b1, 1'b0, "en_drop_e61");
    wait_edge(e0 + 50);
    en0 = 1'b1;
    wait_edge(e0 + 60);
    en0 = 1'b0;
    wait_edge(e0 + 65);

    // ---- reset pulse after tiles 0 and 1 released
    rst0 = 1'b1; en0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    e0 = cyc + 1;
    push(e0+25, 0, 4'b1100, 4'b0000, 1'b0, 1'b1, "pulse_pre");
    push(e0+26, 0, 4'b1111, 4'b0000, 1'b0, 1'b1, "pulse_reset");
    wait_edge(e0 + 25);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    e1 = cyc + 1;
    push(e1+19, 0, 4'b1111, 4'b0000, 1'b0, 1'b1, "rerun_hold");
    push(e1+20, 0, 4'b1110, 4'b0000, 1'b0, 1'b1, "rerun_t0");
    push(e1+24, 0, 4'b1100, 4'b0000, 1'b0, 1'b1, "rerun_t1");
    push(e1+32, 0, 4'b0000, 4'b0000, 1'b1, 1'b0, "rerun_done");
    push(e1+33, 0, 4'b0000, 4'b1111, 1'b1, 1'b0, "rerun_cpu_en");
    wait_edge(e1 + 40);

    // ---- reset and processors_en both high while in RUN
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    en0  = 1'b1; en1  = 1'b1; en2  = 1'b1;
    push(cyc+1, 0, 4'b1111, 4'b0000, 1'b0, 1'b1, "reset_wins");
    push(cyc+1, 1, 4'b1111, 4'b0000, 1'b0, 1'b1, "reset_wins");
    push(cyc+1, 2, 4'b0001, 4'b0000, 1'b0, 1'b1, "reset_wins");
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    repeat (3) @(negedge clk);

    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s d%0d: expectation for edge %0d left unchecked",
               sb[i].name, sb[i].dut, sb[i].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
